// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU definitions: branch/register constants and memory-port
// arbiter types used by mem_port_arbiter and arb_pick.
package mem_port_arbiter_pkg;

  // Register file / branch constants shared across the pipeline
  localparam int unsigned NUM_REGS = 32;
  localparam logic [2:0]  BR_EQ    = 3'b000;
  localparam logic [2:0]  BR_NE    = 3'b001;
  localparam logic [2:0]  BR_LT    = 3'b100;
  localparam logic [2:0]  BR_GE    = 3'b101;

  // Memory port arbiter
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_DM = 2'd2
  } arb_state_e;

  localparam logic [3:0]  MEM_WE_READ = 4'b0000;

  // Bit positions in the grant vector
  localparam int unsigned GNT_IF = 0;
  localparam int unsigned GNT_DM = 1;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant selection between the IF and MEM requesters.
// MEM_ARB_RR_EN selects round-robin; otherwise DM has fixed priority.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       req_if,
  input  logic       req_dm,
  input  logic       last_dm,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_RR_EN
  // On contention the side that did not own the last grant wins
  always_comb begin
    gnt = '0;
    if (req_if && req_dm) begin
      if (last_dm) gnt[GNT_IF] = 1'b1;
      else         gnt[GNT_DM] = 1'b1;
    end else begin
      gnt[GNT_IF] = req_if;
      gnt[GNT_DM] = req_dm;
    end
  end
`else
  // Pointer has no meaning under fixed priority
  logic unused_last_dm;
  assign unused_last_dm = last_dm;

  // Fixed priority: DM over IF
  always_comb begin
    gnt         = '0;
    gnt[GNT_DM] = req_dm;
    gnt[GNT_IF] = req_if & ~req_dm;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single SRAM port between the IF and MEM pipeline stages.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration
// (default is fixed priority, DM over IF).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic [3:0]        dm_we_i,
  input  logic [31:0]       dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              if_stall_o,
  output logic              dm_stall_o
);

  arb_state_e        state_q, state_d;
  logic [1:0]        gnt;
  logic              arb_en;
  logic              req_if_m, req_dm_m;
  logic              last_dm;
  logic [3:0]        we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Byte offset and bits above the SRAM size are not used
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                              dm_addr_i[31:ADDR_W+2], dm_addr_i[1:0]};

  // Arbitrate when idle or in the ack cycle; the completing side is masked
  // so a chained grant always goes to the other requester.
  assign arb_en   = (state_q == ARB_IDLE) | mem_ack_i;
  assign req_if_m = arb_en & if_req_i & (state_q != ARB_BUSY_IF);
  assign req_dm_m = arb_en & dm_req_i & (state_q != ARB_BUSY_DM);

  arb_pick u_arb_pick (
    .req_if  (req_if_m),
    .req_dm  (req_dm_m),
    .last_dm (last_dm),
    .gnt     (gnt)
  );

`ifdef MEM_ARB_RR_EN
  logic last_dm_q;

  // Priority pointer: remembers the owner of the most recent grant
  always_ff @(posedge clk) begin
    if (rst)       last_dm_q <= 1'b0;
    else if (|gnt) last_dm_q <= gnt[GNT_DM];
  end

  assign last_dm = last_dm_q;
`else
  assign last_dm = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a grant always wins; otherwise an ack returns to IDLE
  always_comb begin
    state_d = state_q;
    if (gnt[GNT_DM])                               state_d = ARB_BUSY_DM;
    else if (gnt[GNT_IF])                          state_d = ARB_BUSY_IF;
    else if ((state_q != ARB_IDLE) && mem_ack_i)   state_d = ARB_IDLE;
  end

  // Command registers: captured on a grant, held stable while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (gnt[GNT_DM]) begin
      we_q    <= dm_we_i;
      addr_q  <= dm_addr_i[ADDR_W+1:2];
      wdata_q <= dm_wdata_i;
    end else if (gnt[GNT_IF]) begin
      we_q    <= MEM_WE_READ;
      addr_q  <= if_addr_i[ADDR_W+1:2];
      wdata_q <= '0;
    end
  end

  // Outputs: ack routing (reset abandons the transaction) and stalls
  always_comb begin
    mem_req_o  = (state_q != ARB_IDLE);
    if_ack_o   = (state_q == ARB_BUSY_IF) & mem_ack_i & ~rst;
    dm_ack_o   = (state_q == ARB_BUSY_DM) & mem_ack_i & ~rst;
    if_stall_o = if_req_i & ~if_ack_o;
    dm_stall_o = dm_req_i & ~dm_ack_o;
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = mem_rdata_i;
  assign dm_rdata_o  = mem_rdata_i;

endmodule
